// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared definitions for the memory responder slice: FSM state encoding,
//   data width and the default number of wait states.
package mem_responder_pkg;

    localparam int DATA_BITS           = 32;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array
//   Single-port synchronous RAM, 2^ADDR_BITS words of 32 bits.
//   Ports:
//     clk   - clock
//     we    - write enable, writes wdata to addr on the rising edge
//     re    - read enable, loads rdata from addr on the rising edge
//     addr  - word address shared by read and write
//     wdata - write data
//     rdata - registered read data, holds its value while re is low
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory slave for a multicycle datapath. Accepts one request at a time,
//   inserts WAIT_CYCLES wait states, then pulses ready for one cycle.
//   Addresses with any bit set at or above ADDR_BITS are out of range:
//   err is raised with ready, writes are dropped and reads return zero.
//   Ports:
//     clk   - clock
//     rst   - synchronous active-high reset (storage is not cleared)
//     req   - request strobe, sampled only in IDLE
//     we    - 1 = write, 0 = read
//     adr   - word address
//     wdata - write data
//     rdata - read data, held until the next read response
//     ready - one-cycle response pulse
//     busy  - high while a request is in flight
//     err   - out-of-range flag, only meaningful with ready
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [31:0]          adr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 ready,
    output logic                 busy,
    output logic                 err
);

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    function automatic logic in_range(input logic [31:0] a);
        return a[31:ADDR_BITS] == '0;
    endfunction

    state_t                 state;
    logic [3:0]             cnt;
    logic [31:0]            cap_adr;
    logic                   cap_we;
    logic [DATA_BITS-1:0]   cap_wdata;
    logic                   rd_zero;

    logic                   accept;
    logic [31:0]            sel_adr;
    logic                   sel_we;
    logic                   sel_ok;
    logic                   to_resp;
    logic                   ram_we;
    logic                   ram_re;
    logic [ADDR_BITS-1:0]   ram_addr;
    logic [DATA_BITS-1:0]   ram_q;

    // In IDLE the live inputs describe the request being accepted this edge;
    // afterwards only the captured copy matters. With zero wait states the
    // accepting edge is also the edge entering RESP, so the read must be
    // launched from the live inputs.
    assign accept   = (state == IDLE) && req;
    assign sel_adr  = (state == IDLE) ? adr : cap_adr;
    assign sel_we   = (state == IDLE) ? we  : cap_we;
    assign sel_ok   = in_range(sel_adr);
    assign to_resp  = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));
    assign ram_addr = sel_adr[ADDR_BITS-1:0];

    // The RAM output register only loads on the edge entering RESP of an
    // in-range read, so it holds the last read word until the next one.
    assign ram_re   = to_resp && !sel_we && sel_ok && !rst;
    assign ram_we   = (state == RESP) && cap_we && in_range(cap_adr) && !rst;

    // rd_zero covers both reset and out-of-range reads without clearing RAM.
    assign rdata    = rd_zero ? '0 : ram_q;

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (cap_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_adr   <= adr;
            cap_we    <= we;
            cap_wdata <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            rd_zero <= 1'b1;
        end else begin
            ready <= to_resp;
            err   <= to_resp && !sel_ok;
            if (to_resp && !sel_we) begin
                rd_zero <= !sel_ok;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int WA = 2;
    localparam int WB = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_a, we_a, req_b, we_b;
    logic [31:0] adr_a, wdata_a, adr_b, wdata_b;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, busy_a, err_a, ready_b, busy_b, err_b;

    int   cyc;
    int   checks;
    int   errors;
    exp_t q_a[$];
    exp_t q_b[$];

    mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(WA)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .adr(adr_a), .wdata(wdata_a),
        .rdata(rdata_a), .ready(ready_a), .busy(busy_a), .err(err_a)
    );

    mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(WB)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .adr(adr_b), .wdata(wdata_b),
        .rdata(rdata_b), .ready(ready_b), .busy(busy_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitors: pop one expected entry per ready pulse.
    always @(negedge clk) begin
        if (ready_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_ready: got ready=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_latency", 32'(cyc), 32'(e.cyc));
                chk("a_err", {31'd0, err_a}, {31'd0, e.err});
                chk("a_rdata", rdata_a, e.rdata);
            end
        end else begin
            chk("a_err_low", {31'd0, err_a}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (ready_b === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_ready: got ready=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_latency", 32'(cyc), 32'(e.cyc));
                chk("b_err", {31'd0, err_b}, {31'd0, e.err});
                chk("b_rdata", rdata_b, e.rdata);
            end
        end else begin
            chk("b_err_low", {31'd0, err_b}, 32'd0);
        end
    end

    // One request on DUT A; inputs are scrambled after acceptance.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + 1 + WA;
        q_a.push_back(e);
        req_a = 1'b1; we_a = w; adr_a = a; wdata_a = d;
        @(posedge clk); #1;
        req_a = 1'b0; we_a = ~w; adr_a = 32'hDEAD_BEEF; wdata_a = 32'h5555_AAAA;
        repeat (WA + 1) @(posedge clk);
        #1;
    endtask

    logic [31:0] b_words [4];

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        b_words[0] = 32'h1111_0000;
        b_words[1] = 32'h2222_0001;
        b_words[2] = 32'h3333_0002;
        b_words[3] = 32'h4444_0003;
        rst = 1'b1;
        req_a = 1'b0; we_a = 1'b0; adr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; adr_b = '0; wdata_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_ready", {31'd0, ready_a}, 32'd0);
            chk("rst_busy", {31'd0, busy_a}, 32'd0);
            chk("rst_rdata", rdata_a, 32'd0);
        end
        @(posedge clk); #1;

        // Preload, write then read
        do_req(1'b1, 32'd0,     32'hA5A5_0000, 32'd0, 1'b0);
        do_req(1'b1, 32'd3,     32'h0000_0333, 32'd0, 1'b0);
        do_req(1'b1, 32'd7,     32'h0000_0777, 32'd0, 1'b0);
        do_req(1'b1, 32'd9,     32'h0909_0909, 32'd0, 1'b0);
        do_req(1'b1, 32'd5,     32'hE3A0_1001, 32'd0, 1'b0);
        do_req(1'b0, 32'd5,     32'd0,         32'hE3A0_1001, 1'b0);

        // Out of range: write dropped (word 0 must not alias), read returns 0
        do_req(1'b1, 32'h400,   32'h1234,      32'hE3A0_1001, 1'b1);
        do_req(1'b0, 32'h400,   32'd0,         32'd0,         1'b1);
        do_req(1'b0, 32'd0,     32'd0,         32'hA5A5_0000, 1'b0);

        // Busy ignore, mid-flight input change, req during ready
        e.rdata = 32'h0000_0333; e.err = 1'b0; e.cyc = cyc + 1 + WA;
        q_a.push_back(e);
        req_a = 1'b1; we_a = 1'b0; adr_a = 32'd3;
        @(posedge clk); #1;
        req_a = 1'b0; adr_a = 32'd9;
        @(posedge clk); #1;
        chk("busy_inflight", {31'd0, busy_a}, 32'd1);
        req_a = 1'b1; we_a = 1'b1; adr_a = 32'd7; wdata_a = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req_a = 1'b1; we_a = 1'b0; adr_a = 32'd7;
        e.rdata = 32'h0000_0777; e.err = 1'b0; e.cyc = cyc + 2 + WA;
        q_a.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_a = 1'b0; adr_a = 32'd1;
        repeat (WA + 1) @(posedge clk);
        #1;

        // Reset mid-write aborts the write
        req_a = 1'b1; we_a = 1'b1; adr_a = 32'd9; wdata_a = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req_a = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_rdata", rdata_a, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        do_req(1'b0, 32'd9,     32'd0,         32'h0909_0909, 1'b0);

        // Top in-range word and a high-bit out-of-range address
        do_req(1'b1, 32'h3FF,   32'hCAFE_F00D, 32'h0909_0909, 1'b0);
        do_req(1'b0, 32'h3FF,   32'd0,         32'hCAFE_F00D, 1'b0);
        do_req(1'b0, 32'h8000_0005, 32'd0,     32'd0,         1'b1);

        // Zero-wait instance: req held high, one accept every 2nd cycle
        req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.rdata = 32'd0; e.err = 1'b0; e.cyc = cyc + 1 + WB;
            q_b.push_back(e);
            we_b = 1'b1; adr_b = 32'(i); wdata_b = b_words[i];
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            e.rdata = b_words[i]; e.err = 1'b0; e.cyc = cyc + 1 + WB;
            q_b.push_back(e);
            we_b = 1'b0; adr_b = 32'(i);
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        req_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        chk("a_pending", 32'(q_a.size()), 32'd0);
        chk("b_pending", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10; word-address width of storage, giving 1024 words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2; wait states inserted between request acceptance and response, legal range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  1  request strobe from the multicycle datapath.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port adr  input  32  word address (PC advances by 1 per instruction).
REQ-008 SHALL have port wdata  input  32  write data (datapath B register).
REQ-009 SHALL have port rdata  output  32  read data (feeds datapath IR/MDR).
REQ-010 SHALL have port ready  output  1  one-cycle response pulse.
REQ-011 SHALL have port busy  output  1  high while a request is in flight.
REQ-012 SHALL have port err  output  1  out-of-range flag, valid only with ready.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE, SHALL accept a request when req=1 and capture adr, we and wdata into internal registers on that edge.
REQ-015 After acceptance, SHALL enter WAIT when WAIT_CYCLES>0, otherwise enter RESP directly.
REQ-016 In WAIT, SHALL decrement a 4-bit counter loaded with WAIT_CYCLES-1, and SHALL enter RESP when the counter is 0.
REQ-017 Latency SHALL be WAIT_CYCLES+1 cycles from the accepting edge to the edge at which ready is observed high.
REQ-018 In RESP, SHALL assert ready for exactly one cycle, then return to IDLE.
REQ-019 SHALL hold busy high in WAIT and RESP, and low in IDLE.
REQ-020 SHALL ignore req while busy=1; no queuing.
REQ-021 Read: SHALL update rdata with the word at the captured address so that the value is valid in the ready cycle.
REQ-022 SHALL hold rdata stable until the next read response, so the datapath may sample it late.
REQ-023 Write: SHALL commit wdata to the captured address at the RESP edge, and SHALL leave rdata unchanged.
REQ-024 A request is in range iff captured adr[31:ADDR_BITS] == 0.
REQ-025 Out of range: SHALL assert err with ready, suppress any write, and drive rdata to 32'h0 on a read.
REQ-026 SHALL keep err low whenever ready is low.
REQ-027 Changes on adr, we or wdata after acceptance SHALL NOT affect the in-flight request.
REQ-028 When req=1 in the same cycle ready=1, the request SHALL be ignored; it is accepted only in a following IDLE cycle.
REQ-029 Back-to-back: a req held high continuously SHALL be accepted every WAIT_CYCLES+2 cycles.

Reset
REQ-030 On rst=1 at a clock edge, SHALL move to IDLE and clear the counter, ready, busy, err and rdata to 0.
REQ-031 rst SHALL take priority over req.
REQ-032 Reset mid-operation SHALL abort the request; an aborted write SHALL NOT modify storage.
REQ-033 Storage contents SHALL NOT be cleared by rst.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the default WAIT_CYCLES constant.
REQ-035 Storage SHALL be one sub-module, mem_array: single-port synchronous RAM, 2^ADDR_BITS x 32, one write-enable, registered read.
REQ-036 The FSM, counter, capture registers and range check SHALL reside in mem_responder.

Verification
REQ-037 Reset then idle: rst held 2 cycles, req=0 -> ready=0, busy=0, err=0, rdata=0 for 10 cycles.
REQ-038 Write then read: write adr=5, wdata=32'hE3A0_1001, then read adr=5 -> ready exactly 3 cycles after each accept (WAIT_CYCLES=2), read rdata=32'hE3A0_1001, err=0.
REQ-039 Out of range: write adr=32'h400 data 32'h1234, then read adr=32'h400 and read adr=0 -> err=1 on both 0x400 responses, read rdata=0, word 0 unchanged.
REQ-040 Busy ignore and input change: req pulsed at accept+1 with adr=7, and adr changed mid-flight -> single response for the originally captured address only.
REQ-041 Reset mid-write: accept write adr=9 data 32'hFFFF_FFFF, assert rst in WAIT, then read adr=9 -> prior value returned, no ready during or after the aborted request.
REQ-042 Zero-wait build: WAIT_CYCLES=0, req held high for reads of adr=0..3 -> ready every 2nd cycle, rdata matches preloaded words in order.
